// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port controller.
// Shares the single write port between the in-order WriteBack stage and a
// long-latency unit (LLU). WB normally has priority; an LLU result that keeps
// losing is granted by a one-cycle FORCE state that stalls WB. A per-register
// pending-write scoreboard lets Decode detect RAW hazards on LLU results.
`timescale 1ns/1ps

module regfile_wb_arbiter #(
    parameter int XLEN     = 32,
    parameter int NREG     = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    pipe_wen,
    input  logic [$clog2(NREG)-1:0] pipe_rd,
    input  logic [XLEN-1:0]         pipe_data,
    input  logic                    llu_valid,
    input  logic [$clog2(NREG)-1:0] llu_rd,
    input  logic [XLEN-1:0]         llu_data,
    output logic                    llu_ready,
    input  logic                    issue_en,
    input  logic [$clog2(NREG)-1:0] issue_rd,
    input  logic [$clog2(NREG)-1:0] rs1,
    input  logic [$clog2(NREG)-1:0] rs2,
    output logic                    rs1_busy,
    output logic                    rs2_busy,
    output logic                    stall_wb,
    output logic                    sb_err,
    output logic                    regWEn,
    output logic [$clog2(NREG)-1:0] rd,
    output logic [XLEN-1:0]         dataW
);

    localparam int RW = $clog2(NREG);
    localparam int CW = $clog2(MAX_WAIT + 1);

    typedef enum logic {
        ARB   = 1'b0,
        FORCE = 1'b1
    } state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   wait_cnt_reg, wait_cnt_next;
    logic            sb_err_reg, sb_err_next;
    logic [NREG-1:0] busy_vec;
    logic [NREG-1:0] set_vec;
    logic [NREG-1:0] clr_vec;

    logic pipe_req;
    logic pipe_grant;
    logic llu_grant;
    logic force_stall;
    logic issue_busy;

    // Writes to x0 are meaningless, so they never request the port.
    assign pipe_req = pipe_wen && (pipe_rd != '0);

    // Arbitration and blocked-LLU wait counter.
    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        pipe_grant    = 1'b0;
        llu_grant     = 1'b0;
        force_stall   = 1'b0;
        case (state_reg)
            ARB: begin
                pipe_grant = pipe_req;
                llu_grant  = llu_valid && !pipe_req;
                if (llu_valid && !llu_grant) begin
                    if (wait_cnt_reg == CW'(MAX_WAIT - 1)) begin
                        state_next    = FORCE;
                        wait_cnt_next = '0;
                    end else begin
                        wait_cnt_next = wait_cnt_reg + CW'(1);
                    end
                end else if (llu_grant) begin
                    wait_cnt_next = '0;
                end
            end
            FORCE: begin
                // WB holds its contents; the starved LLU result owns the port.
                force_stall   = 1'b1;
                llu_grant     = llu_valid;
                state_next    = ARB;
                wait_cnt_next = '0;
            end
            default: begin
                state_next    = ARB;
                wait_cnt_next = '0;
            end
        endcase
    end

    // FSM state and wait counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ARB;
            wait_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
        end
    end

    // One scoreboard bit per architectural register; x0 never becomes busy.
    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_busy
            logic bit_reg;

            assign set_vec[gi]  = issue_en && (gi != 0) && (issue_rd == RW'(gi));
            assign clr_vec[gi]  = llu_grant && (llu_rd == RW'(gi));
            assign busy_vec[gi] = bit_reg;

            // Set has priority so a re-issue in the retiring cycle stays pending.
            always_ff @(posedge clk) begin
                if (rst) begin
                    bit_reg <= 1'b0;
                end else if (set_vec[gi]) begin
                    bit_reg <= 1'b1;
                end else if (clr_vec[gi]) begin
                    bit_reg <= 1'b0;
                end
            end
        end
    endgenerate

    // A register whose result retires this cycle is no longer outstanding.
    assign issue_busy  = busy_vec[issue_rd] && !(llu_grant && (llu_rd == issue_rd));
    assign sb_err_next = sb_err_reg || (issue_en && (issue_rd != '0) && issue_busy);

    // Sticky scoreboard error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            sb_err_reg <= 1'b0;
        end else begin
            sb_err_reg <= sb_err_next;
        end
    end

    // Write-port mux; everything is forced low while reset is asserted.
    always_comb begin
        regWEn = 1'b0;
        rd     = '0;
        dataW  = '0;
        if (!rst) begin
            if (llu_grant) begin
                regWEn = (llu_rd != '0);
                rd     = llu_rd;
                dataW  = llu_data;
            end else if (pipe_grant) begin
                regWEn = 1'b1;
                rd     = pipe_rd;
                dataW  = pipe_data;
            end
        end
    end

    assign llu_ready = llu_grant && !rst;
    assign stall_wb  = force_stall && !rst;
    assign sb_err    = sb_err_reg && !rst;

    // Results written this cycle reach the file on the negedge, so they are readable.
    assign rs1_busy = !rst && (rs1 != '0) && busy_vec[rs1] && !(llu_grant && (llu_rd == rs1));
    assign rs2_busy = !rst && (rs2 != '0) && busy_vec[rs2] && !(llu_grant && (llu_rd == rs2));

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: single-cycle vector table,
// hand-written multi-cycle sequences, and a randomized run against a
// behavioural model of arbitration starvation and the pending-write set.
`timescale 1ns/1ps

module tb_regfile_wb_arbiter;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int MW   = 4;

    logic        clk;
    logic        rst;
    logic        pipe_wen;
    logic [4:0]  pipe_rd;
    logic [31:0] pipe_data;
    logic        llu_valid;
    logic [4:0]  llu_rd;
    logic [31:0] llu_data;
    logic        llu_ready;
    logic        issue_en;
    logic [4:0]  issue_rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        rs1_busy;
    logic        rs2_busy;
    logic        stall_wb;
    logic        sb_err;
    logic        regWEn;
    logic [4:0]  rd;
    logic [31:0] dataW;

    regfile_wb_arbiter #(
        .XLEN(XLEN),
        .NREG(NREG),
        .MAX_WAIT(MW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .pipe_wen(pipe_wen),
        .pipe_rd(pipe_rd),
        .pipe_data(pipe_data),
        .llu_valid(llu_valid),
        .llu_rd(llu_rd),
        .llu_data(llu_data),
        .llu_ready(llu_ready),
        .issue_en(issue_en),
        .issue_rd(issue_rd),
        .rs1(rs1),
        .rs2(rs2),
        .rs1_busy(rs1_busy),
        .rs2_busy(rs2_busy),
        .stall_wb(stall_wb),
        .sb_err(sb_err),
        .regWEn(regWEn),
        .rd(rd),
        .dataW(dataW)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        r;
        logic        pw;
        logic [4:0]  prd;
        logic [31:0] pd;
        logic        lv;
        logic [4:0]  lrd;
        logic [31:0] ld;
        logic        e_ready;
        logic        e_wen;
        logic [4:0]  e_rd;
        logic [31:0] e_data;
    } vec_t;

    function automatic vec_t mk(logic r, logic pw, logic [4:0] prd, logic [31:0] pd,
                                logic lv, logic [4:0] lrd, logic [31:0] ld,
                                logic er, logic ew, logic [4:0] erd, logic [31:0] ed);
        vec_t v;
        v.r = r; v.pw = pw; v.prd = prd; v.pd = pd;
        v.lv = lv; v.lrd = lrd; v.ld = ld;
        v.e_ready = er; v.e_wen = ew; v.e_rd = erd; v.e_data = ed;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic e_ready, input logic e_wen,
                           input logic [4:0] e_rd, input logic [31:0] e_data,
                           input logic e_stall, input logic e_rs1b, input logic e_rs2b,
                           input logic e_sb);
        chk({tag, ".llu_ready"}, 64'(llu_ready), 64'(e_ready));
        chk({tag, ".regWEn"},    64'(regWEn),    64'(e_wen));
        chk({tag, ".rd"},        64'(rd),        64'(e_rd));
        chk({tag, ".dataW"},     64'(dataW),     64'(e_data));
        chk({tag, ".stall_wb"},  64'(stall_wb),  64'(e_stall));
        chk({tag, ".rs1_busy"},  64'(rs1_busy),  64'(e_rs1b));
        chk({tag, ".rs2_busy"},  64'(rs2_busy),  64'(e_rs2b));
        chk({tag, ".sb_err"},    64'(sb_err),    64'(e_sb));
    endtask

    task automatic idle();
        pipe_wen = 1'b0; pipe_rd = '0; pipe_data = '0;
        llu_valid = 1'b0; llu_rd = '0; llu_data = '0;
        issue_en = 1'b0; issue_rd = '0; rs1 = '0; rs2 = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        tick();
        rst = 1'b0;
    endtask

    vec_t        vecs[9];
    logic [31:0] m_busy;
    int          m_denied;
    logic        m_sb;

    initial begin
        logic        llu_done;
        logic        forced, preq, e_ready, e_wen, e_rs1b, e_rs2b, e_ib;
        logic [4:0]  e_rd;
        logic [31:0] e_data;

        rst = 1'b1;
        idle();

        // ---------------- single-cycle vectors, each from reset ----------------
        vecs[0] = mk(1, 1, 5'd5, 32'hA5,   1, 5'd9, 32'h1234, 0, 0, 5'd0, 32'h0);
        vecs[1] = mk(0, 1, 5'd5, 32'hA5,   0, 5'd0, 32'h0,    0, 1, 5'd5, 32'hA5);
        vecs[2] = mk(0, 1, 5'd0, 32'hFF,   0, 5'd0, 32'h0,    0, 0, 5'd0, 32'h0);
        vecs[3] = mk(0, 0, 5'd0, 32'h0,    1, 5'd9, 32'h1234, 1, 1, 5'd9, 32'h1234);
        vecs[4] = mk(0, 0, 5'd0, 32'h0,    1, 5'd0, 32'h55,   1, 0, 5'd0, 32'h55);
        vecs[5] = mk(0, 1, 5'd3, 32'h11,   1, 5'd4, 32'h22,   0, 1, 5'd3, 32'h11);
        vecs[6] = mk(0, 1, 5'd0, 32'h11,   1, 5'd4, 32'h22,   1, 1, 5'd4, 32'h22);
        vecs[7] = mk(0, 0, 5'd0, 32'h0,    0, 5'd0, 32'h0,    0, 0, 5'd0, 32'h0);
        vecs[8] = mk(0, 0, 5'd6, 32'h99,   0, 5'd0, 32'h0,    0, 0, 5'd0, 32'h0);

        for (int i = 0; i < 9; i++) begin
            do_reset();
            rst = vecs[i].r;
            pipe_wen = vecs[i].pw; pipe_rd = vecs[i].prd; pipe_data = vecs[i].pd;
            llu_valid = vecs[i].lv; llu_rd = vecs[i].lrd; llu_data = vecs[i].ld;
            settle();
            chk_out($sformatf("vec%0d", i), vecs[i].e_ready, vecs[i].e_wen,
                    vecs[i].e_rd, vecs[i].e_data, 1'b0, 1'b0, 1'b0, 1'b0);
            $display("vec %0d: rst=%0d pipe(%0d,%0d,%h) llu(%0d,%0d,%h) -> ready=%0d wen=%0d rd=%0d data=%h",
                     i, rst, pipe_wen, pipe_rd, pipe_data, llu_valid, llu_rd, llu_data,
                     llu_ready, regWEn, rd, dataW);
            tick();
        end

        // ---------------- issue then LLU writeback clears busy ----------------
        do_reset();
        issue_en = 1'b1; issue_rd = 5'd7; rs1 = 5'd7;
        settle();
        chk_out("issue7", 0, 0, 5'd0, 32'h0, 0, 0, 0, 0);
        tick();
        idle(); rs1 = 5'd7;
        settle();
        chk_out("busy7", 0, 0, 5'd0, 32'h0, 0, 1, 0, 0);
        tick();
        llu_valid = 1'b1; llu_rd = 5'd7; llu_data = 32'h1234; rs1 = 5'd7;
        settle();
        chk_out("grant7", 1, 1, 5'd7, 32'h1234, 0, 0, 0, 0);
        tick();
        idle(); rs1 = 5'd7;
        settle();
        chk_out("after7", 0, 0, 5'd0, 32'h0, 0, 0, 0, 0);
        $display("seq issue/writeback rd=7 done");
        tick();

        // ---------------- starvation forces one WB stall ----------------
        do_reset();
        for (int c = 0; c < 6; c++) begin
            pipe_wen = 1'b1; pipe_rd = 5'(c + 1); pipe_data = 32'(c);
            if (c < 5) begin
                llu_valid = 1'b1; llu_rd = 5'd10; llu_data = 32'hBEEF;
            end else begin
                llu_valid = 1'b0; llu_rd = '0; llu_data = '0;
            end
            settle();
            if (c == 4)
                chk_out($sformatf("starve_c%0d", c), 1, 1, 5'd10, 32'hBEEF, 1, 0, 0, 0);
            else
                chk_out($sformatf("starve_c%0d", c), 0, 1, 5'(c + 1), 32'(c), 0, 0, 0, 0);
            $display("seq starve cycle %0d: stall_wb=%0d llu_ready=%0d rd=%0d", c, stall_wb, llu_ready, rd);
            tick();
        end

        // ---------------- set-wins, sb_err sticky, rd=0 result ----------------
        do_reset();
        issue_en = 1'b1; issue_rd = 5'd3;
        settle();
        chk_out("sb_c0", 0, 0, 5'd0, 32'h0, 0, 0, 0, 0);
        tick();
        issue_en = 1'b1; issue_rd = 5'd3;
        llu_valid = 1'b1; llu_rd = 5'd3; llu_data = 32'h77; rs1 = 5'd3;
        settle();
        chk_out("sb_c1", 1, 1, 5'd3, 32'h77, 0, 0, 0, 0);
        tick();
        idle(); rs1 = 5'd3;
        settle();
        chk_out("sb_c2", 0, 0, 5'd0, 32'h0, 0, 1, 0, 0);
        tick();
        idle(); issue_en = 1'b1; issue_rd = 5'd3; rs2 = 5'd3;
        settle();
        chk_out("sb_c3", 0, 0, 5'd0, 32'h0, 0, 0, 1, 0);
        tick();
        idle();
        settle();
        chk_out("sb_c4", 0, 0, 5'd0, 32'h0, 0, 0, 0, 1);
        tick();
        idle(); issue_en = 1'b1; issue_rd = 5'd6;
        settle();
        chk_out("sb_c5", 0, 0, 5'd0, 32'h0, 0, 0, 0, 1);
        tick();
        idle(); llu_valid = 1'b1; llu_rd = 5'd0; llu_data = 32'h66; rs1 = 5'd6;
        settle();
        chk_out("rd0_grant", 1, 0, 5'd0, 32'h66, 0, 1, 0, 1);
        tick();
        idle(); rs2 = 5'd6;
        settle();
        chk_out("rd0_after", 0, 0, 5'd0, 32'h0, 0, 0, 1, 1);
        $display("seq scoreboard set-wins / sticky sb_err done");
        tick();

        // ---------------- reset under contention ----------------
        do_reset();
        for (int c = 0; c < 3; c++) begin
            idle();
            issue_en = (c == 0); issue_rd = 5'd8;
            pipe_wen = 1'b1; pipe_rd = 5'd2; pipe_data = 32'(c);
            llu_valid = 1'b1; llu_rd = 5'd12; llu_data = 32'hC0DE;
            settle();
            chk_out($sformatf("prerst_c%0d", c), 0, 1, 5'd2, 32'(c), 0, 0, 0, 0);
            tick();
        end
        rst = 1'b1; rs1 = 5'd8;
        settle();
        chk_out("in_rst", 0, 0, 5'd0, 32'h0, 0, 0, 0, 0);
        tick();
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            idle();
            pipe_wen = 1'b1; pipe_rd = 5'd2; pipe_data = 32'(c + 16);
            llu_valid = 1'b1; llu_rd = 5'd13; llu_data = 32'hF00D; rs1 = 5'd8;
            settle();
            if (c == 4)
                chk_out($sformatf("postrst_c%0d", c), 1, 1, 5'd13, 32'hF00D, 1, 0, 0, 0);
            else
                chk_out($sformatf("postrst_c%0d", c), 0, 1, 5'd2, 32'(c + 16), 0, 0, 0, 0);
            $display("seq post-reset cycle %0d: stall_wb=%0d llu_ready=%0d", c, stall_wb, llu_ready);
            tick();
        end

        // ---------------- randomized run against behavioural model ----------------
        do_reset();
        m_busy = '0; m_denied = 0; m_sb = 1'b0;
        llu_done = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if (llu_done) begin
                llu_valid = 1'b0;
                llu_done  = 1'b0;
            end
            rst       = ($urandom_range(0, 99) == 0);
            pipe_wen  = ($urandom_range(0, 2) != 0);
            pipe_rd   = 5'($urandom_range(0, 7));
            pipe_data = $urandom;
            if (!llu_valid && ($urandom_range(0, 2) == 0)) begin
                llu_valid = 1'b1;
                llu_rd    = 5'($urandom_range(0, 7));
                llu_data  = $urandom;
            end
            issue_en = ($urandom_range(0, 3) == 0);
            issue_rd = 5'($urandom_range(0, 7));
            rs1      = 5'($urandom_range(0, 7));
            rs2      = 5'($urandom_range(0, 7));
            settle();
            if (rst) begin
                chk_out("rnd_rst", 0, 0, 5'd0, 32'h0, 0, 0, 0, 0);
                m_busy = '0; m_denied = 0; m_sb = 1'b0;
                llu_done = 1'b1;
            end else begin
                // A result denied MAX_WAIT times is granted on the next cycle by stalling WB.
                forced  = (m_denied == MW);
                preq    = pipe_wen && (pipe_rd != 0);
                e_ready = llu_valid && (forced || !preq);
                e_wen = 1'b0; e_rd = '0; e_data = '0;
                if (e_ready) begin
                    e_wen = (llu_rd != 0); e_rd = llu_rd; e_data = llu_data;
                end else if (preq && !forced) begin
                    e_wen = 1'b1; e_rd = pipe_rd; e_data = pipe_data;
                end
                e_rs1b = (rs1 != 0) && m_busy[rs1] && !(e_ready && llu_rd == rs1);
                e_rs2b = (rs2 != 0) && m_busy[rs2] && !(e_ready && llu_rd == rs2);
                e_ib   = (issue_rd != 0) && m_busy[issue_rd] && !(e_ready && llu_rd == issue_rd);
                chk_out($sformatf("rnd%0d", n), e_ready, e_wen, e_rd, e_data, forced,
                        e_rs1b, e_rs2b, m_sb);
                if (e_ready) begin
                    $display("rnd %0d: llu accept rd=%0d data=%h forced=%0d", n, llu_rd, llu_data, forced);
                    m_denied = 0;
                    if (llu_rd != 0) m_busy[llu_rd] = 1'b0;
                    llu_done = 1'b1;
                end else if (llu_valid) begin
                    m_denied++;
                end
                if (issue_en && issue_rd != 0) begin
                    if (e_ib) m_sb = 1'b1;
                    m_busy[issue_rd] = 1'b1;
                end
            end
            tick();
        end
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
